// File: rtl/div8x4_seq.sv
// div8x4_seq: sequential signed 8/4 restoring divider with start/done handshake and ZF/DZ/OF flags
module div8x4_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [3:0] b,
   output logic [7:0] q,
   output logic [3:0] r,
   output logic       busy,
   output logic       done,
   output logic       ZF,
   output logic       DZ,
   output logic       OF
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state;
   logic sa, sb, neg, ge;
   logic [7:0] sh, qs;
   logic [3:0] mb, pr, rs, cnt;
   logic [4:0] t, d;
   // one restoring step and the sign-corrected final result
   always_comb begin
      t   = {pr, sh[7]};
      d   = t - {1'b0, mb};
      ge  = ~d[4];
      neg = sa ^ sb;
      qs  = neg ? ~sh + 8'd1 : sh;
      rs  = sa ? ~pr + 4'd1 : pr;
   end
   // control FSM; sh holds the dividend and fills with quotient bits from the LSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sa    <= 1'b0;
         sb    <= 1'b0;
         sh    <= '0;
         mb    <= '0;
         pr    <= '0;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ZF    <= 1'b0;
         DZ    <= 1'b0;
         OF    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sa  <= a[7];
               sb  <= b[3];
               sh  <= a[7] ? ~a + 8'd1 : a;
               mb  <= b[3] ? ~b + 4'd1 : b;
               pr  <= '0;
               cnt <= '0;
               if (b == 4'd0) begin
                  q    <= '0;
                  r    <= '0;
                  DZ   <= 1'b1;
                  ZF   <= 1'b1;
                  OF   <= 1'b0;
                  done <= 1'b1;
               end else begin
                  state <= CALC;
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               pr    <= ge ? d[3:0] : t[3:0];
               sh    <= {sh[6:0], ge};
               cnt   <= cnt + 4'd1;
               state <= (cnt == 4'd7) ? FIX : CALC;
            end
            FIX: begin
               q     <= qs;
               r     <= rs;
               ZF    <= (qs == 8'd0);
               DZ    <= 1'b0;
               OF    <= (sh == 8'h80) && !neg;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div8x4_seq.sv
// tb_div8x4_seq: directed and swept checks of the sequential signed divider
module tb_div8x4_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0] a = '0, q;
   logic [3:0] b = '0, r;
   logic busy, done, ZF, DZ, OF;
   int n_chk = 0, n_fail = 0, lat, bc;

   div8x4_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .q(q), .r(r),
                   .busy(busy), .done(done), .ZF(ZF), .DZ(DZ), .OF(OF));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // issue one division; lat = edges after the start edge until done is seen
   task automatic go(input logic [7:0] av, input logic [3:0] bv);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      bc = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1 lat++;
         if (busy) bc++;
      end
   endtask

   task automatic res(input string tag, input logic [7:0] eq, input logic [3:0] er,
                      input logic ez, input logic edz, input logic eof);
      check(tag, {q, r, ZF, DZ, OF}, {eq, er, ez, edz, eof});
   endtask

   initial begin
      int seen, qi, ri;
      #12;
      check("reset_outs", {q, r, busy, done, ZF, DZ, OF}, '0);
      @(negedge clk) rst = 1'b0;

      go(8'h64, 4'd7);
      check("pos_lat", lat, 9);
      check("pos_busy", bc, 9);
      res("pos", 8'h0E, 4'd2, 0, 0, 0);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      go(8'h9C, 4'd7);  res("neg_a", 8'hF2, 4'hE, 0, 0, 0);
      go(8'h64, 4'h8);  res("neg_b", 8'hF4, 4'd4, 0, 0, 0);
      go(8'h03, 4'd7);  res("zero_q", 8'h00, 4'd3, 1, 0, 0);
      go(8'h80, 4'hF);  res("ovf", 8'h80, 4'd0, 0, 0, 1);
      go(8'h80, 4'h1);  res("m128_1", 8'h80, 4'd0, 0, 0, 0);
      go(8'h05, 4'h0);
      check("dz_lat", lat, 0);
      res("dz", 8'h00, 4'd0, 1, 1, 0);
      go(8'h64, 4'd7);  res("dz_clear", 8'h0E, 4'd2, 0, 0, 0);

      // start pulse during busy must be ignored
      @(negedge clk);
      a = 8'h9C; b = 4'h8; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      a = 8'h05; b = 4'h1; start = 1'b1;
      @(negedge clk) start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin @(posedge clk); #1 lat++; end
      check("ign_timeout", lat < 20, 1);
      res("ign_start", 8'h0C, 4'hC, 0, 0, 0);

      // start held high through done: second division starts at once
      go(8'h64, 4'd7);
      @(negedge clk);
      start = 1'b1;
      a = 8'h64; b = 4'd7;
      lat = 0;
      while (!done && lat < 20) begin @(posedge clk); #1 lat++; end
      res("b2b_first", 8'h0E, 4'd2, 0, 0, 0);
      a = 8'h9C;
      @(posedge clk); #1 start = 1'b0;
      check("b2b_busy", busy, 1);
      lat = 0;
      while (!done && lat < 20) begin @(posedge clk); #1 lat++; end
      check("b2b_lat", lat, 9);
      res("b2b_second", 8'hF2, 4'hE, 0, 0, 0);

      // asynchronous reset mid-division
      @(negedge clk);
      a = 8'h64; b = 4'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("rst_async", {q, r, busy, done, ZF, DZ, OF}, '0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (15) begin @(posedge clk); #1 if (done) seen++; end
      check("rst_no_done", seen, 0);
      go(8'h9C, 4'h8);
      check("rst_after_lat", lat, 9);
      res("rst_after", 8'h0C, 4'hC, 0, 0, 0);

      // full sweep against integer division (truncating toward zero)
      for (int ai = 0; ai < 256; ai++) begin
         for (int bi = 1; bi < 16; bi++) begin
            logic [7:0] av;
            logic [3:0] bv;
            logic [31:0] qv, rv;
            av = ai[7:0];
            bv = bi[3:0];
            qi = int'($signed(av)) / int'($signed(bv));
            ri = int'($signed(av)) % int'($signed(bv));
            qv = qi;
            rv = ri;
            go(av, bv);
            check($sformatf("sweep %h/%h", av, bv), {q, r, ZF, DZ, OF, 8'(lat)},
                  {qv[7:0], rv[3:0], qv[7:0] == 8'd0, 1'b0, qi == 128, 8'd9});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
